// File: rtl/store_buffer_pkg.sv
// Shared constants and helpers for the store buffer and its forwarding selector.
package store_buffer_pkg;

    localparam int unsigned RV32_ADDR_WIDTH = 32;
    localparam int unsigned RV32_DATA_WIDTH = 32;

    localparam int unsigned STBUF_DEPTH = 8;
    localparam int unsigned STBUF_SEL   = 3;
    localparam int unsigned STBUF_COM_W = 2;

    // Loads and stores are compared on word address; byte offset is ignored.
    function automatic logic word_match(input logic [RV32_ADDR_WIDTH-1:0] a,
                                        input logic [RV32_ADDR_WIDTH-1:0] b);
        return a[RV32_ADDR_WIDTH-1:2] == b[RV32_ADDR_WIDTH-1:2];
    endfunction

endpackage

// File: rtl/stbuf_fwd_sel.sv
// Youngest-match selector: rotated priority encode starting just below the tail
// and walking backwards with wrap, followed by a one-hot data mux.
module stbuf_fwd_sel
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = STBUF_DEPTH,
    parameter int unsigned SEL   = STBUF_SEL
) (
    input  logic [DEPTH-1:0]                      i_valid,
    input  logic [DEPTH-1:0]                      i_match,
    input  logic [SEL-1:0]                        i_tail_idx,
    input  logic [DEPTH-1:0][RV32_DATA_WIDTH-1:0] i_data,
    output logic [DEPTH-1:0]                      o_onehot,
    output logic                                  o_hit,
    output logic [RV32_DATA_WIDTH-1:0]            o_data
);

    logic [DEPTH-1:0] hit_v;
    logic [SEL-1:0]   idx;
    logic             found;

    // Search tail-1, tail-2, ... so the first hit is the youngest store.
    always_comb begin
        hit_v    = i_valid & i_match;
        o_onehot = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = i_tail_idx - SEL'(k + 1);
            if (!found && hit_v[idx]) begin
                o_onehot[idx] = 1'b1;
                found         = 1'b1;
            end
        end
        o_hit = |hit_v;
    end

    // One-hot OR mux; yields zero when nothing hits.
    always_comb begin
        o_data = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (o_onehot[j]) begin
                o_data = o_data | i_data[j];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the LSU and data memory: holds executed stores
// until retirement, drains retired stores when the port is free, and forwards
// the youngest matching store to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = STBUF_DEPTH,
    parameter int unsigned SEL   = STBUF_SEL,
    parameter int unsigned COM_W = STBUF_COM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_exfin_st,
    input  logic [RV32_ADDR_WIDTH-1:0] i_exfin_st_addr,
    input  logic [RV32_DATA_WIDTH-1:0] i_exfin_st_data,
    output logic                       o_full,
    input  logic [RV32_ADDR_WIDTH-1:0] i_ld_addr,
    output logic                       o_addr_hit,
    output logic [RV32_DATA_WIDTH-1:0] o_rd_data,
    input  logic [1:0]                 i_com_st_num,
    input  logic                       i_kill,
    input  logic                       i_dmem_occupy,
    output logic                       o_dmem_we,
    output logic [RV32_ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [RV32_DATA_WIDTH-1:0] o_dmem_wdata
);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [SEL:0] head_q, head_d;
    logic [SEL:0] com_q,  com_d;
    logic [SEL:0] tail_q, tail_d;
    logic [SEL:0] count;

    logic [DEPTH-1:0][RV32_ADDR_WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][RV32_DATA_WIDTH-1:0] data_q;

    logic             push;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] fwd_onehot;
    logic [SEL-1:0]   off;

    // Occupancy, push qualification, drain request and pointer next-state.
    always_comb begin
        count        = tail_q - head_q;
        o_full       = (count == (SEL+1)'(DEPTH));
        push         = i_exfin_st && !o_full && !i_kill;
        o_dmem_we    = (head_q != com_q) && !i_dmem_occupy;
        o_dmem_addr  = addr_q[head_q[SEL-1:0]];
        o_dmem_wdata = data_q[head_q[SEL-1:0]];
        head_d       = head_q + (SEL+1)'(o_dmem_we);
        com_d        = com_q + (SEL+1)'(i_com_st_num);
        // Retirement in the kill cycle is honoured before the flush.
        tail_d       = i_kill ? com_d : tail_q + (SEL+1)'(push);
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            com_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            com_q  <= com_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage; contents are only meaningful inside [head, tail).
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q[SEL-1:0]] <= i_exfin_st_addr;
            data_q[tail_q[SEL-1:0]] <= i_exfin_st_data;
        end
    end

    // Live-entry mask and per-entry word-address compare against the load.
    always_comb begin
        valid = '0;
        match = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = SEL'(i) - head_q[SEL-1:0];
            valid[i] = ({1'b0, off} < count);
            match[i] = word_match(i_ld_addr, addr_q[i]);
        end
    end

    stbuf_fwd_sel #(
        .DEPTH (DEPTH),
        .SEL   (SEL)
    ) u_fwd_sel (
        .i_valid    (valid),
        .i_match    (match),
        .i_tail_idx (tail_q[SEL-1:0]),
        .i_data     (data_q),
        .o_onehot   (fwd_onehot),
        .o_hit      (o_addr_hit),
        .o_data     (o_rd_data)
    );

    logic unused_fwd;
    assign unused_fwd = ^fwd_onehot;

    // The ROB may never retire more stores than are executed and unretired.
    a_com_legal: assert property (@(posedge clk) disable iff (rst)
        (32'(i_com_st_num) <= COM_W) && ((SEL+1)'(i_com_st_num) <= (tail_q - com_q)));

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue model of unretired and retired
// stores predicts drains, forwarding and fullness every cycle.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_exfin_st;
    logic [31:0] i_exfin_st_addr;
    logic [31:0] i_exfin_st_data;
    logic        o_full;
    logic [31:0] i_ld_addr;
    logic        o_addr_hit;
    logic [31:0] o_rd_data;
    logic [1:0]  i_com_st_num;
    logic        i_kill;
    logic        i_dmem_occupy;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .i_exfin_st      (i_exfin_st),
        .i_exfin_st_addr (i_exfin_st_addr),
        .i_exfin_st_data (i_exfin_st_data),
        .o_full          (o_full),
        .i_ld_addr       (i_ld_addr),
        .o_addr_hit      (o_addr_hit),
        .o_rd_data       (o_rd_data),
        .i_com_st_num    (i_com_st_num),
        .i_kill          (i_kill),
        .i_dmem_occupy   (i_dmem_occupy),
        .o_dmem_we       (o_dmem_we),
        .o_dmem_addr     (o_dmem_addr),
        .o_dmem_wdata    (o_dmem_wdata)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } st_t;

    st_t pend_q[$];  // pushed, not yet retired
    st_t exp_q[$];   // retired, expected on dmem in this order

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    logic        s_we, s_push, s_kill;
    logic [1:0]  s_ret;
    logic [31:0] s_a, s_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge and compare outputs against the model.
    task automatic drive(input logic push, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] ret, input logic kill, input logic occ,
                         input logic [31:0] ld);
        int          cnt;
        logic        e_hit;
        logic [31:0] e_data;
        @(negedge clk);
        i_exfin_st      = push;
        i_exfin_st_addr = a;
        i_exfin_st_data = d;
        i_com_st_num    = ret;
        i_kill          = kill;
        i_dmem_occupy   = occ;
        i_ld_addr       = ld;
        s_push = push; s_a = a; s_d = d; s_ret = ret; s_kill = kill;
        #1;
        cnt = exp_q.size() + pend_q.size();
        check("full", o_full, 32'(cnt == DEPTH));
        check("dmem_we", o_dmem_we, 32'(exp_q.size() != 0 && !occ));
        if (o_dmem_we && exp_q.size() != 0) begin
            check("dmem_addr", o_dmem_addr, exp_q[0].a);
            check("dmem_wdata", o_dmem_wdata, exp_q[0].d);
        end
        e_hit  = 1'b0;
        e_data = '0;
        for (int k = pend_q.size() - 1; k >= 0 && !e_hit; k--) begin
            if (pend_q[k].a[31:2] == ld[31:2]) begin
                e_hit  = 1'b1;
                e_data = pend_q[k].d;
            end
        end
        for (int k = exp_q.size() - 1; k >= 0 && !e_hit; k--) begin
            if (exp_q[k].a[31:2] == ld[31:2]) begin
                e_hit  = 1'b1;
                e_data = exp_q[k].d;
            end
        end
        check("addr_hit", o_addr_hit, 32'(e_hit));
        check("rd_data", o_rd_data, e_data);
        s_we = o_dmem_we;
    endtask

    // Advance the model across the rising edge: drain, retire, then kill/push.
    task automatic tick();
        int cnt;
        cnt = exp_q.size() + pend_q.size();
        @(posedge clk);
        if (s_we) begin
            n_writes++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        for (int i = 0; i < int'(s_ret); i++) begin
            if (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
        end
        if (s_kill) pend_q.delete();
        else if (s_push && cnt < DEPTH) pend_q.push_back('{s_a, s_d});
    endtask

    task automatic step(input logic push, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] ret, input logic kill, input logic occ,
                        input logic [31:0] ld);
        drive(push, a, d, ret, kill, occ, ld);
        tick();
    endtask

    task automatic drain_wait();
        int g = 0;
        while (exp_q.size() != 0 && g < 40) begin
            step(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, '0);
            g++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic retire_all();
        int g = 0;
        while (pend_q.size() != 0 && g < 40) begin
            step(1'b0, '0, '0, (pend_q.size() >= 2) ? 2'd2 : 2'd1, 1'b0, 1'b0, '0);
            g++;
        end
        drain_wait();
    endtask

    initial begin
        int w0;
        int r;
        rst = 1'b1;
        i_exfin_st = 1'b0; i_exfin_st_addr = '0; i_exfin_st_data = '0;
        i_ld_addr = '0; i_com_st_num = '0; i_kill = 1'b0; i_dmem_occupy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_full", o_full, 0);
        check("rst_hit", o_addr_hit, 0);
        check("rst_rd_data", o_rd_data, 0);
        check("rst_dmem_we", o_dmem_we, 0);

        // Three buffered stores, nothing retired: forward middle one, no drain.
        step(1'b1, 32'h100, 32'hA, 2'd0, 1'b0, 1'b0, 32'h104);
        step(1'b1, 32'h104, 32'hB, 2'd0, 1'b0, 1'b0, 32'h104);
        step(1'b1, 32'h108, 32'hC, 2'd0, 1'b0, 1'b0, 32'h104);
        drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 32'h104);
        check("t1_hit", o_addr_hit, 1);
        check("t1_data", o_rd_data, 32'hB);
        check("t1_no_drain", o_dmem_we, 0);
        tick();
        retire_all();

        // Same word twice: youngest wins, byte offset ignored.
        step(1'b1, 32'h200, 32'h1, 2'd0, 1'b0, 1'b0, '0);
        step(1'b1, 32'h200, 32'h2, 2'd0, 1'b0, 1'b0, '0);
        drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 32'h202);
        check("t2_hit", o_addr_hit, 1);
        check("t2_data", o_rd_data, 32'h2);
        tick();
        drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 32'h204);
        check("t2_miss_hit", o_addr_hit, 0);
        check("t2_miss_data", o_rd_data, 0);
        tick();
        step(1'b0, '0, '0, 2'd0, 1'b1, 1'b0, '0);

        // Fill, overflow push dropped, retire two, drains in order.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h400 + 32'(4 * i), 32'h40 + 32'(i), 2'd0, 1'b0, 1'b0, '0);
        end
        drive(1'b1, 32'h500, 32'h99, 2'd0, 1'b0, 1'b0, 32'h500);
        check("t3_full", o_full, 1);
        tick();
        step(1'b0, '0, '0, 2'd2, 1'b0, 1'b0, 32'h500);
        drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 32'h500);
        check("t3_drain0_addr", o_dmem_addr, 32'h400);
        check("t3_still_full", o_full, 1);
        tick();
        drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, '0);
        check("t3_drain1_addr", o_dmem_addr, 32'h404);
        check("t3_full_fall", o_full, 0);
        tick();

        // Port busy holds retired stores back.
        step(1'b0, '0, '0, 2'd2, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 32'h408);
            check("t4_hold", o_dmem_we, 0);
            tick();
        end
        drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, '0);
        check("t4_rel0", o_dmem_addr, 32'h408);
        tick();
        drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, '0);
        check("t4_rel1", o_dmem_addr, 32'h40c);
        tick();
        step(1'b0, '0, '0, 2'd0, 1'b1, 1'b0, '0);
        drain_wait();

        // Retire two in the kill cycle: only those two reach memory.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h600 + 32'(4 * i), 32'h60 + 32'(i), 2'd0, 1'b0, 1'b0, '0);
        end
        step(1'b1, 32'h700, 32'h77, 2'd2, 1'b1, 1'b0, '0);
        w0 = n_writes;
        drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 32'h608);
        check("t5_killed_miss", o_addr_hit, 0);
        tick();
        drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 32'h700);
        check("t5_dropped_miss", o_addr_hit, 0);
        tick();
        drain_wait();
        check("t5_writes", n_writes - w0, 2);

        // Mixed traffic across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            r = (pend_q.size() >= 2) ? 2 : pend_q.size();
            step(1'($urandom_range(0, 1)),
                 32'h800 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
                 $urandom,
                 2'($urandom_range(0, r)),
                 1'b0,
                 1'($urandom_range(0, 3) == 0),
                 32'h800 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)));
        end
        retire_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the load/store execution unit.
- Accepts executed stores (address and data) and holds them in program order until the reorder buffer retires them.
- Drains retired stores to data memory when the load path is not using the memory port.
- Provides store-to-load forwarding: the load address is matched against all buffered stores and the youngest hit is returned.

Parameters:
- DEPTH, default 8: number of entries; must be a power of 2, 2..32.
- SEL, default 3: log2(DEPTH).
- COM_W, default 2: maximum stores retired per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_exfin_st  in  1  executed store valid (push request).
- i_exfin_st_addr  in  32  store byte address.
- i_exfin_st_data  in  32  store data (full word).
- o_full  out  1  buffer full; the execution unit holds the store.
- i_ld_addr  in  32  load address for forwarding lookup.
- o_addr_hit  out  1  some buffered store matches the load word address.
- o_rd_data  out  32  data of the youngest matching store.
- i_com_st_num  in  2  number of stores the ROB retires this cycle, 0..COM_W.
- i_kill  in  1  mispredict flush.
- i_dmem_occupy  in  1  load is using the dmem port this cycle.
- o_dmem_we  out  1  dmem write enable.
- o_dmem_addr  out  32  dmem write address.
- o_dmem_wdata  out  32  dmem write data.

Behaviour:
- Storage:
  - Circular array of DEPTH entries, each holding {addr, data}.
  - Three pointers of SEL+1 bits (the extra bit is the wrap bit): head (oldest entry), com (first unretired entry), tail (next free entry).
  - Order invariant: head <= com <= tail, in modulo order.
  - count = tail - head, SEL+1 bits.
- Reset: head = com = tail = 0. Outputs after reset: o_full=0, o_addr_hit=0, o_rd_data=0, o_dmem_we=0.
- o_full: equals (count == DEPTH), from registered state only. A pop in the same cycle does not free space for a push (no full bypass).
- Push: when i_exfin_st && !o_full && !i_kill, write the entry at tail[SEL-1:0] and increment tail. A push while full is dropped; the producer must stall on o_full.
- Retire: com += i_com_st_num.
  - Requirement: i_com_st_num <= tail - com. Violation is illegal and is covered by an assertion.
- Drain:
  - o_dmem_we = (head != com) && !i_dmem_occupy.
  - o_dmem_addr and o_dmem_wdata are the head entry's fields, combinational from registers.
  - When o_dmem_we is high, head increments at the clock edge. Drain rate is 1 store per cycle.
- Kill:
  - tail <= com + i_com_st_num; that is, retirement is applied before the flush in the same cycle.
  - All unretired entries are discarded. Retired entries are kept and continue draining.
  - A push in the same cycle is dropped.
- Forwarding:
  - Combinational. Compare i_ld_addr[31:2] with addr[31:2] of every entry in [head, tail), covering both retired and unretired entries.
  - o_addr_hit = any match. o_rd_data = data of the youngest match, nearest tail, searching backwards with wrap.
  - o_rd_data = 0 when there is no hit.
  - A store pushed in cycle N is visible to lookups from cycle N+1 onwards.
  - A store draining in the current cycle is still visible this cycle.
- Empty (count == 0): no hit and no drain.
- Wrap-around: pointer index fields roll over mod DEPTH; the wrap bit distinguishes full from empty.
- Simultaneous push, retire and drain in one cycle are all legal and independent.
- Reset mid-operation: all entries are lost, including retired stores not yet drained. This is intended behaviour at reset only.

Decomposition:
- constants.vh gets STBUF_DEPTH, STBUF_SEL and STBUF_COM_W.
- Existing RV32_ADDR_WIDTH and RV32_DATA_WIDTH are reused.
- Sub-module stbuf_fwd_sel:
  - Inputs: per-entry valid mask, match vector and tail index.
  - Output: one-hot youngest match, found by a rotated priority encode.
  - Also performs the data mux.

Test Plan:
- Push 3 stores (0x100/0xA, 0x104/0xB, 0x108/0xC), retire 0, i_ld_addr=0x104 -> o_addr_hit=1, o_rd_data=0xB, o_dmem_we=0 throughout.
- Push 0x200/0x1 then 0x200/0x2, then i_ld_addr=0x202 -> hit, o_rd_data=0x2 (youngest wins, word match); i_ld_addr=0x204 -> hit=0, data=0.
- Fill DEPTH=8 entries -> o_full=1; a 9th push is ignored; retire 2 -> o_dmem_we on the next two cycles with the addresses of entries 0 and 1; o_full falls after the first drain edge.
- Hold retired entries with i_dmem_occupy=1 for 3 cycles -> o_dmem_we=0; release -> drains in order, one per cycle.
- Push 5, retire 2 in the same cycle as i_kill=1 -> tail=com=2, count=2, a lookup of killed addresses misses, and exactly 2 dmem writes follow.
- Run 20 push/retire/drain cycles across the pointer wrap -> in-order dmem writes, no lost or duplicated stores; a forwarding hit across the wrap boundary returns the youngest match.
